mem_port_arbiter: RTL

Sequences and shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU control path (fetch and load/store) and the debug/program-loader port. It sits between the control unit/datapath and the memory macro. It serialises accesses, hides the memory's fixed read latency behind a req/done handshake, and gives the control unit a stall signal so it holds its current state until each access completes.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/arb_rr2.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared definitions for the unified-memory port arbiter of the multicycle
//   MIPS core: sequencing FSM state encoding, requester (owner) encodings and
//   the legal range of the memory read latency.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Owner encodings; also used as the bit index of each requester in the
  // two-bit request vector handed to the round-robin picker.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Legal memory read latency, and the counter width that covers it.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

  // True when a latency value can be sequenced by this arbiter.
  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// -----------------------------------------------------------------------------
// arb_rr2
//   Two-way round-robin picker, purely combinational. The previous winner is
//   held by the parent and fed back through last_owner.
//
//   Ports
//     req[1:0]     in   request vector, bit OWN_CPU = CPU, bit OWN_DBG = debug
//     last_owner   in   owner of the most recently completed access
//     lock         in   debug exclusive ownership; CPU is never picked
//     grant_valid  out  a requester is picked
//     grant_id     out  picked requester (OWN_CPU / OWN_DBG)
// -----------------------------------------------------------------------------
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       lock,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_id    = OWN_CPU;
    if (lock) begin
      // Under lock only the debug port may win; an idle debug port means no
      // grant at all, even if the CPU is asking.
      grant_valid = req[OWN_DBG];
      grant_id    = OWN_DBG;
    end else begin
      case (req)
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = OWN_CPU;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = OWN_DBG;
        end
        2'b11: begin
          // Tie: the requester that did not own the last access wins.
          grant_valid = 1'b1;
          grant_id    = ~last_owner;
        end
        default: begin
          grant_valid = 1'b0;
          grant_id    = OWN_CPU;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single unified instruction/data memory of the multicycle MIPS
//   core between the CPU control path and the debug/program-loader port.
//   Accesses are serialised through an IDLE -> ACCESS -> DONE sequence that
//   hides the memory's fixed read latency behind a req/done handshake.
//
//   Parameters
//     AW       address width (byte address, passed through unmodified)
//     DW       data width
//     MEM_LAT  memory read latency in cycles, 1..7
//
//   Ports
//     clock, rst                      rising-edge clock, sync active-high reset
//     cpu_req/we/addr/wdata           CPU request, held until cpu_done
//     cpu_rdata, cpu_done             registered read data and 1-cycle done
//     cpu_stall                       cpu_req & ~cpu_done, freezes control unit
//     dbg_req/we/addr/wdata           debug port request
//     dbg_rdata, dbg_done             debug read data and done
//     dbg_lock                        debug exclusive ownership
//     mem_en/we/addr/wdata, mem_rdata memory macro interface
//     owner                           owner of the current or last access
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clock,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_done,
  input  logic          dbg_lock,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          owner
);

  // Reject latencies the counter cannot sequence.
  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..7");
  end

  // The counter is loaded with MEM_LAT-1 on the grant; ACCESS then lasts
  // exactly MEM_LAT cycles and the read data is captured on its last edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_owner;

  logic             grant_valid;
  logic             grant_id;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  arb_rr2 u_pick (
    .req         ({dbg_req, cpu_req}),
    .last_owner  (last_owner),
    .lock        (dbg_lock),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Request fields of the winning port; only consumed on the grant edge, so
  // req never reaches mem_* combinationally.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_id == OWN_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  // Sequencer with all outputs registered. mem_we doubles as the latched
  // write flag for the access in flight: it is only cleared when ACCESS ends.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OWN_DBG;
      owner      <= OWN_CPU;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_id;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt       <= CNT_LOAD;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == '0) begin
            // Reads update the owner's data register; writes leave it alone.
            if (!mem_we) begin
              if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
              else                  dbg_rdata <= mem_rdata;
            end
            if (owner == OWN_CPU) cpu_done <= 1'b1;
            else                  dbg_done <= 1'b1;
            last_owner <= owner;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;

  // Structural invariants of the sequencer.
  a_done_exclusive: assert property (@(posedge clock) disable iff (rst)
    !(cpu_done && dbg_done));
  a_mem_en_access: assert property (@(posedge clock) disable iff (rst)
    mem_en == (state == ACCESS));
  a_done_state: assert property (@(posedge clock) disable iff (rst)
    (cpu_done || dbg_done) == (state == DONE));

endmodule
